mac_tx_frame: RTL and testbench

MAC_TX_FRAME -- requirements
Module: mac_tx_frame

---
 rtl/mac_tx_frame_if.sv | 24 ++
 rtl/mac_tx_frame.sv | 178 +++++++++++++++++
 tb/tb_mac_tx_frame.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_frame_if.sv
// Transmit request, payload fetch and GMII transmit signals for mac_tx_frame.
// master: the transmitter; slave: the client/PHY side driving requests and payload.
interface mac_tx_frame_if;
    logic [47:0] MAC_src;
    logic [47:0] MAC_dst;
    logic        Tx_start;
    logic [10:0] Tx_len;
    logic        Tx_data_req;
    logic [7:0]  Tx_data;
    logic        Tx_busy;
    logic        Tx_done;
    logic [7:0]  GMII_TXD;
    logic        GMII_TX_EN;

    modport master (
        input  MAC_src, MAC_dst, Tx_start, Tx_len, Tx_data,
        output Tx_data_req, Tx_busy, Tx_done, GMII_TXD, GMII_TX_EN
    );

    modport slave (
        output MAC_src, MAC_dst, Tx_start, Tx_len, Tx_data,
        input  Tx_data_req, Tx_busy, Tx_done, GMII_TXD, GMII_TX_EN
    );
endinterface

// File: rtl/mac_tx_frame.sv
// GMII frame transmitter: preamble/SFD, dst, src, type, payload, optional pad, FCS, then IFG.
// Minimum-payload padding to 46 bytes is compiled in when MAC_TX_MIN_PAD_EN is defined.
module mac_tx_frame #(
    parameter logic [15:0] MAC_TYPE  = 16'hAA55,
    parameter int          MAX_LEN   = 1500,
    parameter int          IFG_BYTES = 12
) (
    input  logic           GMII_RX_CLK,
    input  logic           reset,
    mac_tx_frame_if.master tx
);
    typedef enum logic [3:0] {IDLE, PRE, SFD, DST, SRC, TYPE, DATA, PAD, FCS, IFG} state_t;

    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES - 1);
    localparam logic [15:0] PAD_LAST  = 16'd45;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [95:0] addr_q, addr_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic [10:0] req_rem_q, req_rem_d;
    logic        pad_needed;
    logic [15:0] data_last;

`ifdef MAC_TX_MIN_PAD_EN
    assign pad_needed = (len_q < 11'd46);
`else
    assign pad_needed = 1'b0;
`endif

    assign data_last = {5'd0, len_q} - 16'd1;

    // Reflected (LSB-first) CRC-32 step; register holds the bit-reversed CRC.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        len_d     = len_q;
        addr_d    = addr_q;
        crc_d     = crc_q;
        req_d     = 1'b0;
        req_rem_d = req_rem_q;
        txd_d     = 8'h00;
        en_d      = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx.Tx_start) begin
                    state_d = PRE;
                    len_d   = (tx.Tx_len > MAX_LEN_L) ? MAX_LEN_L : tx.Tx_len;
                    addr_d  = {tx.MAC_dst, tx.MAC_src};
                    crc_d   = '1;
                end
            end
            PRE: if (cnt_q == 16'd6) begin state_d = SFD; cnt_d = '0; end
            SFD: begin state_d = DST; cnt_d = '0; end
            DST: if (cnt_q == 16'd5) begin state_d = SRC; cnt_d = '0; end
            SRC: if (cnt_q == 16'd5) begin state_d = TYPE; cnt_d = '0; end
            TYPE: begin
                if (cnt_q == 16'd1) begin
                    cnt_d = '0;
                    if (len_q != 11'd0) begin
                        state_d = DATA;
                    end else if (pad_needed) begin
                        state_d = PAD;
                    end else begin
                        state_d = FCS;
                    end
                end
            end
            DATA: begin
                if (cnt_q == data_last) begin
                    // Pad index continues from the payload length so it always ends at byte 45.
                    if (pad_needed) begin
                        state_d = PAD;
                        cnt_d   = {5'd0, len_q};
                    end else begin
                        state_d = FCS;
                        cnt_d   = '0;
                    end
                end
            end
            PAD: if (cnt_q == PAD_LAST) begin state_d = FCS; cnt_d = '0; end
            FCS: if (cnt_q == 16'd3) begin state_d = IFG; cnt_d = '0; end
            IFG: if (cnt_q == IFG_LAST) begin state_d = IDLE; cnt_d = '0; end
            default: begin state_d = IDLE; cnt_d = '0; end
        endcase

        // Output register carries the byte belonging to the next state.
        case (state_d)
            PRE: txd_d = 8'h55;
            SFD: txd_d = 8'hD5;
            DST, SRC: begin
                txd_d  = addr_q[95:88];
                addr_d = {addr_q[87:0], 8'h00};
            end
            TYPE: txd_d = cnt_d[0] ? MAC_TYPE[7:0] : MAC_TYPE[15:8];
            DATA: txd_d = tx.Tx_data;
            PAD:  txd_d = 8'h00;
            FCS: begin
                case (cnt_d[1:0])
                    2'd0:    txd_d = ~crc_q[7:0];
                    2'd1:    txd_d = ~crc_q[15:8];
                    2'd2:    txd_d = ~crc_q[23:16];
                    default: txd_d = ~crc_q[31:24];
                endcase
            end
            default: en_d = 1'b0;
        endcase

        if (state_d inside {DST, SRC, TYPE, DATA, PAD}) begin
            crc_d = crc_byte(crc_q, txd_d);
        end

        // Reads start two cycles ahead of DATA to cover the registered RAM and output stage.
        if (state_d == TYPE && state_q != TYPE) begin
            req_d     = (len_q != 11'd0);
            req_rem_d = (len_q != 11'd0) ? len_q - 11'd1 : 11'd0;
        end else if (req_q && req_rem_q != 11'd0) begin
            req_d     = 1'b1;
            req_rem_d = req_rem_q - 11'd1;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == FCS) && (cnt_d == 16'd3);
    end

    always_ff @(posedge GMII_RX_CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            crc_q     <= '1;
            txd_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            req_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            crc_q     <= crc_d;
            txd_q     <= txd_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            req_rem_q <= req_rem_d;
        end
    end

    assign tx.GMII_TXD    = txd_q;
    assign tx.GMII_TX_EN  = en_q;
    assign tx.Tx_busy     = busy_q;
    assign tx.Tx_done     = done_q;
    assign tx.Tx_data_req = req_q;
endmodule

// File: tb/tb_mac_tx_frame.sv
// Bench for mac_tx_frame: expected wire bytes and per-frame results queued at stimulus time.
module tb_mac_tx_frame;
    logic clk = 1'b0;
    logic reset;
    always #4 clk = ~clk;

    mac_tx_frame_if tx_if();

    mac_tx_frame #(.MAC_TYPE(16'hAA55), .MAX_LEN(1500), .IFG_BYTES(12)) dut (
        .GMII_RX_CLK (clk),
        .reset       (reset),
        .tx          (tx_if)
    );

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    int          exp_req_q[$];
    logic [7:0]  payload [2048];
    logic        rd_clr;
    int          rd_ptr;
    logic [31:0] model_crc;

    // Payload RAM with one cycle read latency.
    always @(posedge clk) begin
        if (rd_clr) begin
            rd_ptr <= 0;
        end else if (tx_if.Tx_data_req) begin
            tx_if.Tx_data <= payload[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // MSB-first register, bits fed LSB first: residue over DST..FCS is C704DD7B.
    function automatic logic [31:0] crc_nf(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ b[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    task automatic push_b(input logic [7:0] b, input bit cov);
        exp_q.push_back(b);
        if (cov) model_crc = crc_nf(model_crc, b);
    endtask

    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input int len);
        int          l;
        int          pad;
        logic [31:0] rev;
        logic [31:0] fcs;
        l   = (len > 1500) ? 1500 : len;
        pad = 0;
`ifdef MAC_TX_MIN_PAD_EN
        if (l < 46) pad = 46 - l;
`endif
        model_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) push_b(8'h55, 1'b0);
        push_b(8'hD5, 1'b0);
        for (int i = 0; i < 6; i++) push_b(dst[47-8*i -: 8], 1'b1);
        for (int i = 0; i < 6; i++) push_b(src[47-8*i -: 8], 1'b1);
        push_b(8'hAA, 1'b1);
        push_b(8'h55, 1'b1);
        for (int i = 0; i < l; i++) push_b(payload[i], 1'b1);
        for (int i = 0; i < pad; i++) push_b(8'h00, 1'b1);
        for (int i = 0; i < 32; i++) rev[i] = model_crc[31-i];
        fcs = ~rev;
        push_b(fcs[7:0], 1'b0);
        push_b(fcs[15:8], 1'b0);
        push_b(fcs[23:16], 1'b0);
        push_b(fcs[31:24], 1'b0);
        exp_len_q.push_back(22 + l + pad + 4);
        exp_req_q.push_back(l);
    endtask

    task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input int len,
                             input int mid_at, input bit ifg_kick, input int abort_at);
        int          nbytes, nreq, ndone, done_at, ifg, en_in_ifg, cyc;
        logic [31:0] rx_crc;
        bit          ended;
        push_frame(dst, src, len);
        @(negedge clk);
        tx_if.MAC_dst  = dst;
        tx_if.MAC_src  = src;
        tx_if.Tx_len   = 11'(len);
        tx_if.Tx_start = 1'b1;
        rd_clr         = 1'b1;
        @(negedge clk);
        tx_if.Tx_start = 1'b0;
        rd_clr         = 1'b0;
        check("busy_after_accept", 32'(tx_if.Tx_busy), 1);
        check("en_after_accept", 32'(tx_if.GMII_TX_EN), 1);
        nbytes = 0; nreq = 0; ndone = 0; done_at = -1; ended = 1'b0;
        rx_crc = 32'hFFFFFFFF;
        for (cyc = 0; cyc < 2000; cyc++) begin
            tx_if.Tx_start = 1'b0;
            if (tx_if.Tx_data_req) nreq++;
            if (tx_if.GMII_TX_EN) begin
                nbytes++;
                if (exp_q.size() == 0) check("txd_overrun", 0, 1);
                else check("txd", 32'(tx_if.GMII_TXD), 32'(exp_q.pop_front()));
                if (nbytes > 8) rx_crc = crc_nf(rx_crc, tx_if.GMII_TXD);
            end
            if (tx_if.Tx_done) begin ndone++; done_at = nbytes; end
            if (!tx_if.GMII_TX_EN && nbytes > 0) begin
                check("txd_zero_when_idle", 32'(tx_if.GMII_TXD), 0);
                ended = 1'b1;
                break;
            end
            if (abort_at > 0 && nbytes == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_en", 32'(tx_if.GMII_TX_EN), 0);
                check("abort_done", 32'(tx_if.Tx_done), 0);
                check("abort_busy", 32'(tx_if.Tx_busy), 0);
                reset = 1'b0;
                exp_q.delete();
                void'(exp_len_q.pop_front());
                void'(exp_req_q.pop_front());
                return;
            end
            if (mid_at > 0 && nbytes == mid_at) tx_if.Tx_start = 1'b1;
            @(negedge clk);
        end
        if (!ended) begin
            check("frame_timeout", 0, 1);
            exp_q.delete();
            void'(exp_len_q.pop_front());
            void'(exp_req_q.pop_front());
            return;
        end
        check("frame_len", nbytes, exp_len_q.pop_front());
        check("req_count", nreq, exp_req_q.pop_front());
        check("done_count", ndone, 1);
        check("done_on_last_byte", done_at, nbytes);
        check("fcs_residue", rx_crc, 32'hC704DD7B);
        check("exp_drained", exp_q.size(), 0);
        ifg = 0; en_in_ifg = 0;
        while (tx_if.Tx_busy && ifg < 100) begin
            if (tx_if.GMII_TX_EN) en_in_ifg++;
            tx_if.Tx_start = (ifg_kick && ifg == 3);
            ifg++;
            @(negedge clk);
        end
        tx_if.Tx_start = 1'b0;
        check("ifg_len", ifg, 12);
        check("ifg_en_low", en_in_ifg, 0);
        @(negedge clk);
        @(negedge clk);
        check("idle_en", 32'(tx_if.GMII_TX_EN), 0);
        check("idle_busy", 32'(tx_if.Tx_busy), 0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        rd_clr         = 1'b0;
        tx_if.Tx_start = 1'b0;
        tx_if.Tx_len   = '0;
        tx_if.MAC_dst  = '0;
        tx_if.MAC_src  = '0;
        model_crc      = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("rst_en", 32'(tx_if.GMII_TX_EN), 0);
        check("rst_txd", 32'(tx_if.GMII_TXD), 0);
        check("rst_req", 32'(tx_if.Tx_data_req), 0);
        check("rst_busy", 32'(tx_if.Tx_busy), 0);
        check("rst_done", 32'(tx_if.Tx_done), 0);
        reset = 1'b0;

        payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
        run_frame(48'hFFFFFFFFFFFF, 48'h4B4559000001, 4, 0, 1'b0, 0);

        run_frame(48'h001122334455, 48'h66778899AABB, 0, 0, 1'b0, 0);

        for (int i = 0; i < 50; i++) payload[i] = 8'($urandom_range(0, 255));
        run_frame(48'h0A0B0C0D0E0F, 48'h4B4559000002, 50, 30, 1'b1, 0);

        for (int i = 0; i < 1600; i++) payload[i] = 8'(i * 7 + 3);
        run_frame(48'h123456789ABC, 48'h4B4559000003, 1600, 0, 1'b0, 0);

        for (int i = 0; i < 20; i++) payload[i] = 8'(8'hC0 + i);
        run_frame(48'hFEDCBA987654, 48'h4B4559000004, 20, 0, 1'b0, 17);
        run_frame(48'hFEDCBA987654, 48'h4B4559000004, 20, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
